// File: rtl/crom_fetch_if.sv
// Handshake bundle between the sprite engine, SDRAM port B and the pixel shifter
// and the C-ROM fetch queue. The slave modport is the fetch queue's view.
interface crom_fetch_if #(
  parameter int ADDR_W = 25,
  parameter int LEN_W  = 4,
  parameter int LVL_W  = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              pix_ready;
  logic              busy;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, flush, mem_ack, mem_data, pix_ready,
    output cmd_ready, mem_req, mem_we, mem_addr, pix_valid, pix_data, busy, fifo_level
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, flush, mem_ack, mem_data, pix_ready,
    input  cmd_ready, mem_req, mem_we, mem_addr, pix_valid, pix_data, busy, fifo_level
  );
endinterface

// File: rtl/crom_fetch_queue.sv
// Sprite-side C-ROM fetcher: turns line-fetch commands into single-word reads on SDRAM
// port B and buffers the returned words in a first-word-fall-through FIFO.
module crom_fetch_queue_chk #(
  parameter int FIFO_DEPTH = 32,
  parameter int LVL_W      = 6
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic [LVL_W-1:0] level
);
  // Credit-based issue must never let a returned word land in a full FIFO
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (level < LVL_W'(FIFO_DEPTH)));
endmodule

module crom_fetch_queue #(
  parameter int ADDR_W     = 25,
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input logic         clk,
  input logic         rst,
  crom_fetch_if.slave bus
);
  localparam int LEN_W = $clog2(BURST_MAX);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LEN_W:0] BURST_LEN = (LEN_W+1)'(BURST_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [LEN_W:0]    remain_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [15:0]       fifo_mem_r [FIFO_DEPTH];
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              room_s;

  assign accept_s = (state_r == IDLE) && bus.cmd_valid && !bus.flush;
  assign push_s   = (state_r == ISSUE) && mem_req_r && bus.mem_ack && !bus.flush;
  assign pop_s    = (level_r != LVL_W'(0)) && bus.pix_ready;
  // With at most one read in flight and mem_req low, nothing is pending: level alone is the credit.
  assign room_s   = level_r < LVL_W'(FIFO_DEPTH);

  // Command sequencer: one read in flight, address and count advance on each ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= ADDR_W'(0);
      cur_addr_r <= ADDR_W'(0);
      remain_r   <= (LEN_W+1)'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= ISSUE;
            cur_addr_r <= bus.cmd_addr;
            remain_r   <= (bus.cmd_len == LEN_W'(0)) ? BURST_LEN : {1'b0, bus.cmd_len};
          end
        end
        ISSUE: begin
          if (bus.flush) begin
            if (mem_req_r && !bus.mem_ack) begin
              state_r <= DRAIN;
            end else begin
              state_r   <= IDLE;
              mem_req_r <= 1'b0;
            end
          end else if (mem_req_r) begin
            if (bus.mem_ack) begin
              mem_req_r  <= 1'b0;
              cur_addr_r <= cur_addr_r + ADDR_W'(1);
              remain_r   <= remain_r - (LEN_W+1)'(1);
              if (remain_r == (LEN_W+1)'(1)) begin
                state_r <= IDLE;
              end
            end
          end else if (room_s) begin
            mem_req_r  <= 1'b1;
            mem_addr_r <= cur_addr_r;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.mem_data;
    end
  end

  // FIFO pointers and occupancy; flush empties it regardless of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else if (bus.flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign bus.cmd_ready  = (state_r == IDLE) && !bus.flush;
  assign bus.mem_req    = mem_req_r;
  assign bus.mem_we     = 1'b0;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.pix_valid  = (level_r != LVL_W'(0));
  assign bus.pix_data   = (level_r != LVL_W'(0)) ? fifo_mem_r[rd_ptr_r] : 16'h0000;
  assign bus.busy       = (state_r != IDLE);
  assign bus.fifo_level = level_r;

  crom_fetch_queue_chk #(.FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .level (level_r)
  );
endmodule

// File: tb/tb_crom_fetch_queue.sv
// Directed bench for crom_fetch_queue: an SDRAM port-B responder (auto or hand-fired acks)
// and a pixel-side pop logger; each scenario task checks its own expected values.
module tb_crom_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          ack_delay = 1;
  bit          auto_resp = 1'b0;
  int          man_req = 0;
  int          man_done = 0;
  logic [15:0] man_data = 16'h0000;
  int          resp_cnt = 0;
  logic [24:0] addr_log [$];
  logic [15:0] pop_log [$];

  crom_fetch_if #(.ADDR_W(25), .LEN_W(4), .LVL_W(6)) bus ();

  crom_fetch_queue #(.ADDR_W(25), .BURST_MAX(16), .FIFO_DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Port-B model: one-cycle ack pulses, data = low address bits ^ 0xC3C3 in auto mode
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ack = 1'b0;
      resp_cnt = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (man_req != man_done) begin
      bus.mem_ack = 1'b1;
      bus.mem_data = man_data;
      man_done = man_done + 1;
    end else if (auto_resp && bus.mem_req) begin
      resp_cnt = resp_cnt + 1;
      if (resp_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        bus.mem_data = bus.mem_addr[15:0] ^ 16'hC3C3;
        addr_log.push_back(bus.mem_addr);
        resp_cnt = 0;
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // Record every word the pixel side pops
  always @(negedge clk) begin
    if (!rst && bus.pix_valid && bus.pix_ready) pop_log.push_back(bus.pix_data);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [24:0] a, input logic [3:0] l, output bit ok);
    ok = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_req) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic manual_ack(input logic [15:0] d);
    man_data = d;
    man_req = man_req + 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    chk_cnt++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); else pass_cnt++;
    chk_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", bus.mem_req); else pass_cnt++;
    chk_cnt++; if (bus.mem_addr !== 25'h0) $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); else pass_cnt++;
    chk_cnt++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", bus.mem_we); else pass_cnt++;
    chk_cnt++; if (bus.pix_valid !== 1'b0) $display("FAIL reset_pix_valid got %b want 0", bus.pix_valid); else pass_cnt++;
    chk_cnt++; if (bus.pix_data !== 16'h0) $display("FAIL reset_pix_data got %h want 0", bus.pix_data); else pass_cnt++;
    chk_cnt++; if (bus.fifo_level !== 6'd0) $display("FAIL reset_level got %0d want 0", bus.fifo_level); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_basic();
    bit ok;
    int abase;
    int pbase;
    logic [24:0] ea [4] = '{25'h1000, 25'h1001, 25'h1002, 25'h1003};
    logic [15:0] ed [4] = '{16'hD3C3, 16'hD3C2, 16'hD3C1, 16'hD3C0};
    auto_resp = 1'b1; ack_delay = 3; bus.pix_ready = 1'b0;
    abase = addr_log.size(); pbase = pop_log.size();
    send_cmd(25'h0001000, 4'd4, ok);
    chk_cnt++; if (!ok) $display("FAIL basic_accept got timeout want accept"); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0) $display("FAIL basic_accept_cycle got busy=%b req=%b want 1/0", bus.busy, bus.mem_req); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 25'h1000) $display("FAIL basic_first_req got req=%b addr=%h want 1/1000", bus.mem_req, bus.mem_addr); else pass_cnt++;
    wait_idle(200, ok);
    chk_cnt++; if (!ok) $display("FAIL basic_idle got busy want idle"); else pass_cnt++;
    chk_cnt++; if (bus.fifo_level !== 6'd4) $display("FAIL basic_level got %0d want 4", bus.fifo_level); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (addr_log[abase+i] !== ea[i]) $display("FAIL basic_addr%0d got %h want %h", i, addr_log[abase+i], ea[i]); else pass_cnt++;
    end
    bus.pix_ready = 1'b1;
    step(6);
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (pop_log[pbase+i] !== ed[i]) $display("FAIL basic_data%0d got %h want %h", i, pop_log[pbase+i], ed[i]); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int abase;
    int pbase;
    logic [24:0] ea [4] = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000, 25'h0000001};
    logic [15:0] ed [4] = '{16'h3C3D, 16'h3C3C, 16'hC3C3, 16'hC3C2};
    auto_resp = 1'b1; ack_delay = 2; bus.pix_ready = 1'b1;
    abase = addr_log.size(); pbase = pop_log.size();
    send_cmd(25'h1FFFFFE, 4'd4, ok);
    wait_idle(200, ok);
    chk_cnt++; if (!ok) $display("FAIL wrap_idle got busy want idle"); else pass_cnt++;
    step(4);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++; if (addr_log[abase+i] !== ea[i]) $display("FAIL wrap_addr%0d got %h want %h", i, addr_log[abase+i], ea[i]); else pass_cnt++;
      chk_cnt++; if (pop_log[pbase+i] !== ed[i]) $display("FAIL wrap_data%0d got %h want %h", i, pop_log[pbase+i], ed[i]); else pass_cnt++;
    end
    chk_cnt++; if (bus.fifo_level !== 6'd0) $display("FAIL wrap_level got %0d want 0", bus.fifo_level); else pass_cnt++;
    bus.pix_ready = 1'b0;
  endtask

  task automatic test_full();
    bit ok;
    int abase;
    int pbase;
    int hi = 0;
    int bad_a = 0;
    int bad_d = 0;
    logic [24:0] a;
    logic [15:0] d;
    auto_resp = 1'b1; ack_delay = 1; bus.pix_ready = 1'b0;
    abase = addr_log.size(); pbase = pop_log.size();
    send_cmd(25'h0002000, 4'd0, ok);
    wait_idle(400, ok);
    send_cmd(25'h0002010, 4'd0, ok);
    wait_idle(400, ok);
    chk_cnt++; if (bus.fifo_level !== 6'd32) $display("FAIL full_level got %0d want 32", bus.fifo_level); else pass_cnt++;
    send_cmd(25'h0002020, 4'd0, ok);
    chk_cnt++; if (!ok) $display("FAIL full_third_accept got timeout want accept"); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) hi++;
    end
    chk_cnt++; if (hi != 0) $display("FAIL full_req_stall got %0d high cycles want 0", hi); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b1 || bus.fifo_level !== 6'd32) $display("FAIL full_hold got busy=%b level=%0d want 1/32", bus.busy, bus.fifo_level); else pass_cnt++;
    chk_cnt++; if (addr_log.size() - abase != 32) $display("FAIL full_req_count got %0d want 32", addr_log.size() - abase); else pass_cnt++;
    @(posedge clk); #1;
    bus.pix_ready = 1'b1;
    step(1);
    bus.pix_ready = 1'b0;
    chk_cnt++; if (bus.fifo_level !== 6'd31 || bus.mem_req !== 1'b0) $display("FAIL full_pop_edge got level=%0d req=%b want 31/0", bus.fifo_level, bus.mem_req); else pass_cnt++;
    step(1);
    chk_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL full_resume got req=%b want 1", bus.mem_req); else pass_cnt++;
    bus.pix_ready = 1'b1;
    wait_idle(400, ok);
    step(64);
    bus.pix_ready = 1'b0;
    chk_cnt++; if (bus.fifo_level !== 6'd0) $display("FAIL full_drained got %0d want 0", bus.fifo_level); else pass_cnt++;
    chk_cnt++; if (pop_log.size() - pbase != 48) $display("FAIL full_pop_count got %0d want 48", pop_log.size() - pbase); else pass_cnt++;
    for (int i = 0; i < 48; i++) begin
      a = 25'h0002000 + 25'(i);
      d = a[15:0] ^ 16'hC3C3;
      if (addr_log[abase+i] !== a) bad_a++;
      if (pop_log[pbase+i] !== d) bad_d++;
    end
    chk_cnt++; if (bad_a != 0) $display("FAIL full_addr_order got %0d bad want 0", bad_a); else pass_cnt++;
    chk_cnt++; if (bad_d != 0) $display("FAIL full_data_order got %0d bad want 0", bad_d); else pass_cnt++;
  endtask

  task automatic test_flush();
    bit ok;
    auto_resp = 1'b0; bus.pix_ready = 1'b0;
    bus.flush = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_addr = 25'h0000900; bus.cmd_len = 4'd2;
    #1;
    chk_cnt++; if (bus.cmd_ready !== 1'b0) $display("FAIL flush_cmd_ready got %b want 0", bus.cmd_ready); else pass_cnt++;
    step(1);
    bus.flush = 1'b0; bus.cmd_valid = 1'b0;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL flush_cmd_rejected got busy=%b want 0", bus.busy); else pass_cnt++;
    send_cmd(25'h0000100, 4'd4, ok);
    wait_req(ok);
    manual_ack(16'h1111);
    chk_cnt++; if (bus.fifo_level !== 6'd1) $display("FAIL flush_prefill got %0d want 1", bus.fifo_level); else pass_cnt++;
    wait_req(ok);
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    chk_cnt++; if (bus.fifo_level !== 6'd0 || bus.pix_valid !== 1'b0) $display("FAIL flush_clear got level=%0d valid=%b want 0/0", bus.fifo_level, bus.pix_valid); else pass_cnt++;
    chk_cnt++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) $display("FAIL flush_drain got req=%b busy=%b rdy=%b want 1/1/0", bus.mem_req, bus.busy, bus.cmd_ready); else pass_cnt++;
    step(3);
    chk_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 25'h101) $display("FAIL flush_hold got req=%b addr=%h want 1/101", bus.mem_req, bus.mem_addr); else pass_cnt++;
    manual_ack(16'h2222);
    chk_cnt++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL flush_done got req=%b busy=%b rdy=%b want 0/0/1", bus.mem_req, bus.busy, bus.cmd_ready); else pass_cnt++;
    step(3);
    chk_cnt++; if (bus.fifo_level !== 6'd0 || bus.mem_req !== 1'b0) $display("FAIL flush_dropped got level=%0d req=%b want 0/0", bus.fifo_level, bus.mem_req); else pass_cnt++;
    send_cmd(25'h0000300, 4'd4, ok);
    wait_req(ok);
    manual_ack(16'h3333);
    wait_req(ok);
    man_data = 16'h4444;
    man_req = man_req + 1;
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
    chk_cnt++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.fifo_level !== 6'd0) $display("FAIL flush_ack_same got req=%b busy=%b level=%0d want 0/0/0", bus.mem_req, bus.busy, bus.fifo_level); else pass_cnt++;
    step(2);
    chk_cnt++; if (bus.fifo_level !== 6'd0 || bus.mem_req !== 1'b0) $display("FAIL flush_ack_after got level=%0d req=%b want 0/0", bus.fifo_level, bus.mem_req); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 1'b0;
    auto_resp = 1'b1; ack_delay = 1; bus.pix_ready = 1'b0;
    send_cmd(25'h0000500, 4'd8, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.fifo_level == 6'd5) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    chk_cnt++; if (!seen || bus.mem_req !== 1'b1 || bus.fifo_level !== 6'd5) $display("FAIL rstmid_setup got seen=%b req=%b level=%0d want 1/1/5", seen, bus.mem_req, bus.fifo_level); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (bus.mem_req !== 1'b0 || bus.pix_valid !== 1'b0) $display("FAIL rstmid_outputs got req=%b valid=%b want 0/0", bus.mem_req, bus.pix_valid); else pass_cnt++;
    chk_cnt++; if (bus.fifo_level !== 6'd0 || bus.busy !== 1'b0) $display("FAIL rstmid_state got level=%0d busy=%b want 0/0", bus.fifo_level, bus.busy); else pass_cnt++;
    step(2);
    rst = 1'b0;
    step(2);
    chk_cnt++; if (bus.cmd_ready !== 1'b1 || bus.mem_req !== 1'b0) $display("FAIL rstmid_after got rdy=%b req=%b want 1/0", bus.cmd_ready, bus.mem_req); else pass_cnt++;
  endtask

  task automatic test_pop_ack_same();
    bit ok;
    int to = 0;
    int pbase;
    logic [15:0] d;
    auto_resp = 1'b0; bus.pix_ready = 1'b0;
    send_cmd(25'h0000700, 4'd8, ok);
    for (int k = 1; k <= 7; k++) begin
      wait_req(ok);
      if (!ok) to++;
      d = 16'h0700 + 16'(k);
      manual_ack(d);
      if (k == 1) begin
        chk_cnt++; if (bus.pix_valid !== 1'b1 || bus.pix_data !== 16'h0701) $display("FAIL popack_first got valid=%b data=%h want 1/0701", bus.pix_valid, bus.pix_data); else pass_cnt++;
      end
    end
    chk_cnt++; if (to != 0 || bus.fifo_level !== 6'd7) $display("FAIL popack_fill got timeouts=%0d level=%0d want 0/7", to, bus.fifo_level); else pass_cnt++;
    wait_req(ok);
    pbase = pop_log.size();
    man_data = 16'h0708;
    man_req = man_req + 1;
    bus.pix_ready = 1'b1;
    step(1);
    bus.pix_ready = 1'b0;
    chk_cnt++; if (bus.fifo_level !== 6'd7) $display("FAIL popack_level got %0d want 7", bus.fifo_level); else pass_cnt++;
    chk_cnt++; if (bus.pix_data !== 16'h0702 || bus.busy !== 1'b0) $display("FAIL popack_head got data=%h busy=%b want 0702/0", bus.pix_data, bus.busy); else pass_cnt++;
    bus.pix_ready = 1'b1;
    step(10);
    bus.pix_ready = 1'b0;
    chk_cnt++; if (bus.fifo_level !== 6'd0) $display("FAIL popack_drain got %0d want 0", bus.fifo_level); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      d = 16'h0701 + 16'(i);
      chk_cnt++; if (pop_log[pbase+i] !== d) $display("FAIL popack_order%0d got %h want %h", i, pop_log[pbase+i], d); else pass_cnt++;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = 25'h0;
    bus.cmd_len = 4'd0;
    bus.flush = 1'b0;
    bus.pix_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_flush();
    test_reset_mid();
    test_pop_ack_same();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
